// File: rtl/reset_reg_pkg.sv
// Shared definitions for the reset_reg_pipe register pipeline: count-width helper and stage state.
package reset_reg_pkg;

  typedef enum logic {
    STG_EMPTY = 1'b0,
    STG_FULL  = 1'b1
  } stage_state_e;

  // Ceiling log2. Never returns less than 1, so a counter port is always at least one bit wide.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/reset_reg_stage.sv
// One valid+data pipeline stage. It has load, unload and clear controls and a synchronous active-low reset.
// Optional macro RESET_REG_PIPE_RANDOM_INIT_EN: randomises data and empties the stage at time 0.
module reset_reg_stage
  import reset_reg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             unload_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] q_o
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] data_q;

`ifdef RESET_REG_PIPE_RANDOM_INIT_EN
  initial begin
    state_q = STG_EMPTY;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      data_q[b] = 1'($random);
    end
  end
`endif

  // A simultaneous load and unload leaves the stage full with the new beat.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = STG_EMPTY;
    end else if (load_i) begin
      state_d = STG_FULL;
    end else if (unload_i) begin
      state_d = STG_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STG_EMPTY;
      data_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      if (load_i) begin
        data_q <= d_i;
      end
    end
  end

  assign valid_o = (state_q == STG_FULL);
  assign q_o     = data_q;

endmodule

// File: rtl/reset_reg_pipe.sv
// Elastic register pipeline of DEPTH stages, with flush, occupancy count and synchronous active-low reset.
// Optional macro RESET_REG_PIPE_RANDOM_INIT_EN: the stages start empty at time 0 with random data.
module reset_reg_pipe
  import reset_reg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          flush,
  output logic [clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] d        [DEPTH];
  logic [WIDTH-1:0] stage_in [DEPTH];
  logic             gate;
  logic             accept;
  logic             xfer;
  logic [CW-1:0]    count_q, count_d;

  assign gate = rst_n & ~flush;

  // The ready chain is walked from the output back to the input. Each stage can take a beat
  // when it is empty or when it moves forward in the same cycle, so bubbles collapse.
  always_comb begin
    logic        ok;
    int unsigned idx;
    move     = '0;
    in_ready = 1'b0;
    ok       = out_ready;
    idx      = 0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx       = DEPTH - 1 - k;
      move[idx] = v[idx] & gate & ok;
      ok        = ~v[idx] | move[idx];
    end
    in_ready = gate & ok;
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    load        = '0;
    stage_in[0] = in_data;
    load[0]     = accept;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_in[i] = d[i-1];
      load[i]     = move[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    reset_reg_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load[g]),
      .unload_i (move[g]),
      .clear_i  (flush),
      .d_i      (stage_in[g]),
      .valid_o  (v[g]),
      .q_o      (d[g])
    );
  end

  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];
  assign xfer      = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(accept) - CW'(xfer);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_reset_reg_pipe.sv
// Directed self-checking bench for reset_reg_pipe with WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5.
module tb_reset_reg_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       flush;
  logic [1:0] count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  reset_reg_pipe #(
    .WIDTH       (8),
    .DEPTH       (3),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge, where inputs are changed.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Load three beats with the output stalled, which leaves the pipe full.
  task automatic fill(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] beats [3];
    beats[0] = b0;
    beats[1] = b1;
    beats[2] = b2;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = beats[i];
      #1;
      expect_eq("fill_in_ready", 32'(in_ready), 32'd1);
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b1;
    flush     = 1'b0;

    // Reset is held for two edges while a beat is offered.
    @(posedge clk);
    next_cycle();
    expect_eq("rst_in_ready",  32'(in_ready),  32'd0);
    expect_eq("rst_out_valid", 32'(out_valid), 32'd0);
    expect_eq("rst_out_data",  32'(out_data),  32'hA5);
    expect_eq("rst_count",     32'(count),     32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    expect_eq("idle_in_ready", 32'(in_ready), 32'd1);
    next_cycle();

    // Single beat: visible only in cycle 3, count 1 in cycles 1-3.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    #1;
    expect_eq("single_accept", 32'(in_ready), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      expect_eq("single_out_valid", 32'(out_valid), (c == 3) ? 32'd1 : 32'd0);
      expect_eq("single_count", 32'(count), (c <= 3) ? 32'd1 : 32'd0);
      if (c == 3) expect_eq("single_out_data", 32'(out_data), 32'h3C);
      next_cycle();
    end

    // Stream of 16 beats at full rate: output c-2 appears in cycles 3..18.
    out_ready = 1'b1;
    for (int c = 0; c < 19; c++) begin
      in_valid = (c < 16);
      in_data  = 8'(c + 1);
      #1;
      if (c < 16) expect_eq("stream_in_ready", 32'(in_ready), 32'd1);
      expect_eq("stream_out_valid", 32'(out_valid), (c >= 3) ? 32'd1 : 32'd0);
      if (c >= 3) expect_eq("stream_out_data", 32'(out_data), 32'(c - 2));
      next_cycle();
    end
    in_valid = 1'b0;
    #1;
    expect_eq("stream_drained_count", 32'(count), 32'd0);
    expect_eq("stream_drained_valid", 32'(out_valid), 32'd0);

    // Backpressure: three of four beats fit. Raising out_ready frees the input in the same cycle.
    fill(8'h41, 8'h42, 8'h43);
    in_valid = 1'b1;
    in_data  = 8'h44;
    #1;
    expect_eq("bp_in_ready_full", 32'(in_ready),  32'd0);
    expect_eq("bp_count_full",    32'(count),     32'd3);
    expect_eq("bp_out_valid",     32'(out_valid), 32'd1);
    expect_eq("bp_out_data",      32'(out_data),  32'h41);
    out_ready = 1'b1;
    #1;
    expect_eq("bp_in_ready_release", 32'(in_ready), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      expect_eq("bp_drain_valid", 32'(out_valid), 32'd1);
      expect_eq("bp_drain_data",  32'(out_data),  32'(8'h42 + k));
      next_cycle();
    end
    #1;
    expect_eq("bp_drain_count", 32'(count), 32'd0);

    // Flush with a full pipe and a competing input beat.
    fill(8'h51, 8'h52, 8'h53);
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    #1;
    expect_eq("flush_in_ready",  32'(in_ready),  32'd0);
    expect_eq("flush_out_valid", 32'(out_valid), 32'd0);
    next_cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    expect_eq("flush_count",     32'(count),     32'd0);
    expect_eq("flush_out_valid_after", 32'(out_valid), 32'd0);
    expect_eq("flush_out_data",  32'(out_data),  32'h51);
    expect_eq("flush_in_ready_after", 32'(in_ready), 32'd1);
    next_cycle();
    #1;
    expect_eq("flush_no_ghost", 32'(out_valid), 32'd0);

    // Reset in the middle of a stream takes priority over a live handshake.
    fill(8'h61, 8'h62, 8'h63);
    out_ready = 1'b1;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    #1;
    expect_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    next_cycle();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    expect_eq("midrst_count",     32'(count),     32'd0);
    expect_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    expect_eq("midrst_out_data",  32'(out_data),  32'hA5);

    // The pipe works normally after reset.
    in_valid = 1'b1;
    in_data  = 8'h7E;
    next_cycle();
    in_valid = 1'b0;
    #1;
    expect_eq("post_rst_count", 32'(count), 32'd1);
    next_cycle();
    next_cycle();
    #1;
    expect_eq("post_rst_valid", 32'(out_valid), 32'd1);
    expect_eq("post_rst_data",  32'(out_data),  32'h7E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reset_reg_pipe.md
RESET_REG_PIPE -- requirements
Module: reset_reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_VALUE, default {WIDTH{1'b0}}, value loaded into every data stage on reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream beat present.
REQ-007 SHALL have port in_ready  output  1  stage 0 can accept this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream beat.
REQ-009 SHALL have port out_valid  output  1  last stage holds a beat.
REQ-010 SHALL have port out_ready  input  1  downstream accepts.
REQ-011 SHALL have port out_data  output  WIDTH  last-stage data register, driven whether or not valid.
REQ-012 SHALL have port flush  input  1  synchronous discard of all held beats.
REQ-013 SHALL have port count  output  clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 Each stage i SHALL hold a valid bit v[i] and a WIDTH-bit data register d[i].
REQ-015 Stage i SHALL move when v[i] and (i==DEPTH-1 ? out_ready : (!v[i+1] or move[i+1])); moving empties stage i and loads stage i+1.
REQ-016 in_ready SHALL equal rst_n and !flush and (!v[0] or move[0]); this path is combinational from out_ready.
REQ-017 A beat SHALL be accepted when in_valid and in_ready are both high; it is written into d[0], and v[0] is set.
REQ-018 out_valid SHALL equal v[DEPTH-1] and !flush; a transfer occurs when out_valid and out_ready are both high.
REQ-019 Latency SHALL be DEPTH cycles from acceptance to out_valid with an empty, unstalled pipe.
REQ-020 Throughput SHALL be one beat per cycle when out_ready stays high; bubbles SHALL collapse under backpressure.
REQ-021 Beat order SHALL be preserved; no beat SHALL be duplicated or lost except by flush or reset.
REQ-022 Data registers SHALL load only on a move or accept; otherwise they hold, including when invalid.
REQ-023 flush high SHALL clear all v[i] at the next edge, force in_ready=0 and out_valid=0 that cycle, and leave d[i] unchanged.
REQ-024 flush and in_valid in the same cycle: the input SHALL NOT be accepted.
REQ-025 count SHALL equal the popcount of v registered each cycle, and SHALL track accept minus transfer exactly.

Reset
REQ-026 rst_n low at a posedge SHALL clear all v[i], load all d[i] with RESET_VALUE, and set count to 0.
REQ-027 While rst_n is low, in_ready SHALL be 0 and no beat SHALL be accepted.
REQ-028 Reset SHALL dominate flush and any handshake in the same cycle, including mid-stream with a full pipe.

Configuration
REQ-029 With RESET_REG_PIPE_RANDOM_INIT_EN defined, simulation SHALL initialise every d[i] to $random bits and every v[i] to 0 at time 0.
REQ-030 Without RESET_REG_PIPE_RANDOM_INIT_EN, no initial block SHALL exist, and all state SHALL be X until the first reset edge.

Structure
REQ-031 Package reset_reg_pkg SHALL hold the clog2 function used for the count width and the stage-state typedef.
REQ-032 Sub-module reset_reg_stage SHALL implement one valid+data stage with load, clear and synchronous active-low reset to RESET_VALUE.
REQ-033 reset_reg_pipe SHALL instantiate DEPTH reset_reg_stage in a generate loop, plus the move chain and counter.

Verification (WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5)
REQ-034 Hold rst_n=0 for 2 cycles with in_valid=1, in_data=8'hFF -> out_valid=0, in_ready=0, out_data=8'hA5, count=0.
REQ-035 Single beat 8'h3C accepted at cycle 0, out_ready=1 -> out_valid=1 with out_data=8'h3C at cycle 3 only, count=1 in cycles 1-3.
REQ-036 Stream 8'h01..8'h10 back-to-back with out_ready=1 -> 16 outputs in order, one per cycle, starting cycle 3.
REQ-037 Set out_ready=0 and offer 4 beats -> 3 accepted, then in_ready=0, count=3; raise out_ready -> in_ready=1 the same cycle, order preserved.
REQ-038 flush with a full pipe and in_valid=1 -> no accept, next cycle count=0, out_valid=0, out_data unchanged.
REQ-039 rst_n=0 for one cycle with a full pipe and out_ready=1 -> next cycle count=0, out_valid=0, out_data=8'hA5, no transfer counted.
